// File: rtl/sbox_sched.sv
// Sequences the eight DES S-box lookups of one 48-bit word through a single
// shared S-box unit, one box at a time, and assembles the 32-bit result.
module sbox_sched #(
  parameter int SB_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:48] din,
  output logic [2:0]  sb_sel,
  output logic [1:6]  sb_in,
  input  logic [1:4]  sb_out,
  output logic        busy,
  output logic        done,
  output logic [1:32] dout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  idx;
  logic [2:0]  idx_nx;
  logic [1:48] din_reg;
  logic [1:32] shadow;
  logic [1:32] shadow_nx;
  logic        accept;
  logic        capture;

  // dout is loaded with the fully assembled word, including the nibble
  // captured on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      din_reg <= '0;
      shadow  <= '0;
      dout    <= '0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      shadow <= shadow_nx;
      if (accept) begin
        din_reg <= din;
      end
      if (state_nx == DONE) begin
        dout <= shadow_nx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept   = 1'b1;
          idx_nx   = 3'd0;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (SB_LAT == 0) begin
          capture = 1'b1;
          if (idx == 3'd7) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + 3'd1;
            state_nx = ISSUE;
          end
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        capture = 1'b1;
        if (idx == 3'd7) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx + 3'd1;
          state_nx = ISSUE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    shadow_nx = shadow;
    for (int i = 0; i < 8; i++) begin
      if (capture && (idx == 3'(i))) begin
        shadow_nx[4*i+1 +: 4] = sb_out;
      end
    end
  end

  // The lookup address stays put across ISSUE and WAIT because idx only
  // advances when leaving WAIT.
  always_comb begin
    busy   = (state == ISSUE) || (state == WAIT);
    done   = (state == DONE);
    sb_sel = busy ? idx : 3'd0;
    sb_in  = '0;
    if (busy) begin
      for (int i = 0; i < 8; i++) begin
        if (idx == 3'(i)) begin
          sb_in = din_reg[6*i+1 +: 6];
        end
      end
    end
  end

endmodule

// File: tb/tb_sbox_sched.sv
// Bench for sbox_sched: one instance per lookup latency, DES S-box models on
// the shared lookup port, and a cycle-level reference model of each word.
module tb_sbox_sched;

  localparam logic [255:0] SBT [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
  };

  localparam logic [1:48] ZERO = 48'h0;
  localparam logic [1:48] ONES = 48'hFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic [1:48] din0 = '0;
  logic [1:48] din1 = '0;
  logic [2:0]  sel0, sel1;
  logic [1:6]  in0, in1;
  logic [1:4]  sbo0, sbo1, sbq1;
  logic        busy0, busy1, done0, done1;
  logic [1:32] dout0, dout1;

  int tests  = 0;
  int failed = 0;
  bit chk    = 1'b0;

  int          k  [2];
  logic [1:48] w  [2];
  logic [1:32] md [2];

  always #5 clk = ~clk;

  sbox_sched #(.SB_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start0), .din(din0),
    .sb_sel(sel0), .sb_in(in0), .sb_out(sbo0),
    .busy(busy0), .done(done0), .dout(dout0)
  );

  sbox_sched #(.SB_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start1), .din(din1),
    .sb_sel(sel1), .sb_in(in1), .sb_out(sbo1),
    .busy(busy1), .done(done1), .dout(dout1)
  );

  function automatic logic [1:4] lookup(input logic [2:0] s, input logic [1:6] a);
    int n;
    logic [255:0] t;
    n = int'({a[1], a[6]}) * 16 + int'(a[2:5]);
    t = SBT[s];
    return t[255-4*n -: 4];
  endfunction

  function automatic logic [1:32] sboxword(input logic [1:48] v);
    logic [1:32] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i+1 +: 4] = lookup(3'(i), v[6*i+1 +: 6]);
    end
    return r;
  endfunction

  function automatic int total(input int u);
    return 8 * (u + 1) + 1;
  endfunction

  assign sbo0 = lookup(sel0, in0);
  always @(posedge clk) sbq1 <= lookup(sel1, in1);
  assign sbo1 = sbq1;

  // k counts cycles since a word was accepted: 1..8L are lookups, 8L+1 is
  // the completion cycle, 0 means idle.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        k[u]  <= 0;
        md[u] <= '0;
      end else if (k[u] > 0 && k[u] < total(u)) begin
        k[u] <= k[u] + 1;
        if (k[u] + 1 == total(u)) md[u] <= sboxword(w[u]);
      end else if ((u == 0) ? start0 : start1) begin
        w[u] <= (u == 0) ? din0 : din1;
        k[u] <= 1;
      end else begin
        k[u] <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareUnit(input int u, input logic b, input logic d, input logic [2:0] s,
                             input logic [1:6] a, input logic [1:32] o);
    int kk, es;
    logic eb;
    logic [1:6] ei;
    kk = k[u];
    eb = (kk >= 1) && (kk < total(u));
    es = eb ? (kk - 1) / (u + 1) : 0;
    ei = eb ? w[u][6*es+1 +: 6] : 6'd0;
    checkOutput($sformatf("u%0d_busy", u), 64'(b), 64'(eb));
    checkOutput($sformatf("u%0d_done", u), 64'(d), 64'(kk == total(u)));
    checkOutput($sformatf("u%0d_sb_sel", u), 64'(s), 64'(es));
    checkOutput($sformatf("u%0d_sb_in", u), 64'(a), 64'(ei));
    checkOutput($sformatf("u%0d_dout", u), 64'(o), 64'(md[u]));
  endtask

  always @(negedge clk) begin
    if (chk) begin
      compareUnit(0, busy0, done0, sel0, in0, dout0);
      compareUnit(1, busy1, done1, sel1, in1, dout1);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int u, input logic s, input logic [1:48] d);
    if (u == 0) begin
      start0 = s;
      din0   = d;
    end else begin
      start1 = s;
      din1   = d;
    end
  endtask

  task automatic launch(input int u, input logic [1:48] d);
    applyStimulus(u, 1'b1, d);
    stepCycle();
    applyStimulus(u, 1'b0, d);
  endtask

  task automatic waitDone(input int u, input int lat0, input int limit,
                          output int lat, output int bc, output logic [1:32] d);
    lat = lat0;
    bc  = 0;
    while (!((u == 0) ? done0 : done1) && lat < limit) begin
      if ((u == 0) ? busy0 : busy1) bc++;
      stepCycle();
      lat++;
    end
    if (!((u == 0) ? done0 : done1)) checkOutput($sformatf("u%0d_timeout", u), 64'd0, 64'd1);
    d = (u == 0) ? dout0 : dout1;
  endtask

  initial begin
    int lat, bc;
    logic [1:32] d;
    logic [63:0] r;
    bit sawDone;

    checkOutput("model_zero", 64'(sboxword(ZERO)), 64'hEFA72C4D);
    checkOutput("model_ones", 64'(sboxword(ONES)), 64'hD9CE3DCB);
    checkOutput("model_s3_ones", 64'(lookup(3'd2, 6'b111111)), 64'd12);

    stepCycle();
    chk = 1'b1;
    stepCycle();
    checkOutput("reset_busy", 64'({busy0, busy1}), 64'd0);
    checkOutput("reset_done", 64'({done0, done1}), 64'd0);
    checkOutput("reset_dout", 64'({dout0, dout1}), 64'd0);
    checkOutput("reset_sb", 64'({sel0, in0, sel1, in1}), 64'd0);
    stepCycle();
    rst = 1'b0;
    stepCycle();

    launch(0, ZERO);
    waitDone(0, 1, 30, lat, bc, d);
    checkOutput("zero_latency", 64'(lat), 64'd9);
    checkOutput("zero_busy_cycles", 64'(bc), 64'd8);
    checkOutput("zero_dout", 64'(d), 64'hEFA72C4D);
    stepCycle();

    launch(0, ONES);
    stepCycle();
    stepCycle();
    checkOutput("s3_sel", 64'(sel0), 64'd2);
    checkOutput("s3_in", 64'(in0), 64'b111111);
    checkOutput("s3_out", 64'(sbo0), 64'd12);
    waitDone(0, 3, 30, lat, bc, d);
    checkOutput("ones_latency", 64'(lat), 64'd9);
    checkOutput("ones_dout", 64'(d), 64'hD9CE3DCB);
    stepCycle();

    applyStimulus(0, 1'b1, ZERO);
    stepCycle();
    for (int n = 0; n < 4; n++) begin
      waitDone(0, 1, 30, lat, bc, d);
      checkOutput($sformatf("b2b_latency%0d", n), 64'(lat), 64'd9);
      checkOutput($sformatf("b2b_dout%0d", n), 64'(d), (n % 2 == 0) ? 64'hEFA72C4D : 64'hD9CE3DCB);
      applyStimulus(0, n != 3, (n % 2 == 0) ? ONES : ZERO);
      stepCycle();
    end

    launch(0, ONES);
    stepCycle();
    stepCycle();
    applyStimulus(0, 1'b1, ZERO);
    stepCycle();
    applyStimulus(0, 1'b0, ZERO);
    waitDone(0, 4, 30, lat, bc, d);
    checkOutput("midword_latency", 64'(lat), 64'd9);
    checkOutput("midword_dout", 64'(d), 64'hD9CE3DCB);
    stepCycle();

    launch(0, ONES);
    stepCycle();
    stepCycle();
    stepCycle();
    rst = 1'b1;
    applyStimulus(0, 1'b1, ZERO);
    stepCycle();
    rst = 1'b0;
    applyStimulus(0, 1'b0, ZERO);
    checkOutput("rst_busy", 64'(busy0), 64'd0);
    checkOutput("rst_dout", 64'(dout0), 64'd0);
    checkOutput("rst_done", 64'(done0), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sawDone |= done0;
      stepCycle();
    end
    checkOutput("rst_no_done", 64'(sawDone), 64'd0);
    launch(0, ZERO);
    waitDone(0, 1, 30, lat, bc, d);
    checkOutput("after_rst_dout", 64'(d), 64'hEFA72C4D);
    stepCycle();

    launch(1, ZERO);
    waitDone(1, 1, 40, lat, bc, d);
    checkOutput("lat1_latency", 64'(lat), 64'd17);
    checkOutput("lat1_busy_cycles", 64'(bc), 64'd16);
    checkOutput("lat1_dout", 64'(d), 64'hEFA72C4D);
    stepCycle();

    for (int i = 0; i < 1500; i++) begin
      r = {$urandom, $urandom};
      applyStimulus(0, $urandom_range(0, 2) == 0, r[47:0]);
      r = {$urandom, $urandom};
      applyStimulus(1, $urandom_range(0, 2) == 0, r[47:0]);
      rst = ($urandom_range(0, 99) == 0);
      stepCycle();
    end
    rst = 1'b0;
    applyStimulus(0, 1'b0, ZERO);
    applyStimulus(1, 1'b0, ZERO);
    for (int i = 0; i < 25; i++) stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sbox_sched.md
SBOX_SCHED -- requirements
Module: sbox_sched

Interface
REQ-001 SHALL have parameter SB_LAT, default 0, giving external S-box lookup latency in cycles; legal values are 0 or 1.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to process din; sampled only when busy=0.
REQ-005 SHALL have port din  input  [1:48]  post-key-XOR expanded word; bits 1..6 feed box 1, bits 43..48 feed box 8.
REQ-006 SHALL have port sb_sel  output  [2:0]  index of the shared S-box unit to use; 0 = S1 .. 7 = S8.
REQ-007 SHALL have port sb_in  output  [1:6]  6-bit lookup address to the shared S-box unit.
REQ-008 SHALL have port sb_out  input  [1:4]  4-bit result from the shared S-box unit.
REQ-009 SHALL have port busy  output  1  high while a word is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse; dout is valid.
REQ-011 SHALL have port dout  output  [1:32]  concatenated S1..S8 results; S1 occupies bits 1..4.

Function
REQ-012 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE; WAIT SHALL be used only when SB_LAT=1.
REQ-013 In IDLE or DONE with start=1, the block SHALL latch din into an internal register, clear idx to 0, and enter ISSUE next cycle.
REQ-014 While busy=1 (ISSUE or WAIT), start SHALL be ignored and din SHALL NOT be re-sampled.
REQ-015 In ISSUE, the block SHALL drive sb_sel=idx and sb_in=din_reg[6*idx+1 : 6*idx+6].
REQ-016 With SB_LAT=0, in ISSUE the block SHALL capture sb_out into shadow[4*idx+1 : 4*idx+4] in the same cycle.
REQ-017 With SB_LAT=0, if idx<7 the block SHALL increment idx and stay in ISSUE; if idx=7 it SHALL go to DONE.
REQ-018 With SB_LAT=1, ISSUE SHALL go to WAIT, and sb_sel/sb_in SHALL be held unchanged through WAIT.
REQ-019 With SB_LAT=1, WAIT SHALL capture sb_out into the shadow register, then go to ISSUE with idx+1, or to DONE if idx=7.
REQ-020 On entry to DONE, dout SHALL be loaded from shadow and done SHALL be 1 for exactly that cycle.
REQ-021 Between completions, dout SHALL hold its last value unchanged.
REQ-022 DONE SHALL last one cycle, then go to IDLE, or to ISSUE if start=1 in DONE (back-to-back accepted, no bubble).
REQ-023 busy SHALL be 1 exactly in ISSUE and WAIT.
REQ-024 Latency from the start-accept edge to done=1 SHALL be 9 cycles for SB_LAT=0 and 17 cycles for SB_LAT=1.
REQ-025 In IDLE and DONE, sb_sel and sb_in SHALL be 0.
REQ-026 idx SHALL be 3 bits wide and SHALL never wrap past 7 within a word.
REQ-027 The block SHALL perform no arithmetic on data; it only routes bit fields.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL enter IDLE with idx=0, shadow=0, dout=0, done=0, busy=0, sb_sel=0 and sb_in=0.
REQ-029 rst SHALL take priority over start and over any in-progress word.
REQ-030 A word interrupted by reset SHALL be discarded, with no done pulse and dout=0.
REQ-031 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-032 Bench SHALL model the eight standard DES S-boxes behind sb_sel/sb_in/sb_out, with row = bits 1,6 and column = bits 2..5.
REQ-033 SB_LAT=0, din=48'h0, start pulse -> done at +9 cycles, dout=32'hEFA72C4D, busy high for exactly 8 cycles.
REQ-034 SB_LAT=0, din=48'hFFFFFFFFFFFF -> dout=32'hD9CE3DCB; on the S3 lookup cycle, sb_sel=2, sb_in=6'b111111 and sb_out=12.
REQ-035 SB_LAT=0, start held high continuously, alternating din 0 / all-ones accepted at each DONE -> done every 9 cycles, dout alternating EFA72C4D / D9CE3DCB.
REQ-036 start pulsed mid-word with a different din -> ignored, dout reflects the original din only.
REQ-037 rst asserted 4 cycles after start -> next cycle IDLE, busy=0, dout=0, no done; a subsequent start with din=0 yields EFA72C4D.
REQ-038 SB_LAT=1, din=48'h0 -> done at +17 cycles, dout=32'hEFA72C4D, sb_sel/sb_in stable across each ISSUE/WAIT pair.
